ddr3_pg_ring_mgr: RTL and testbench
===================================

# ddr3_pg_ring_mgr

Page-level ring-buffer manager for the DDR3 waveform store. It runs in the XDOM/logic clock domain and accepts "page filled" and "page wanted" pulses from the DPRAM producer and consumer. It maps them to ring-buffer page indices and drives the four-phase `pg_req`/`pg_optype`/`pg_req_addr`/`pg_ack` handshake of the DDR3–DPRAM transfer block. It owns the write pointer, read pointer and fill count, and applies back-pressure at full and empty.

## Interface
- `PG_BITS`, default 16: log2 of ring size in pages; ring covers pages 0..2^PG_BITS-1; legal range 1..17.
- `clk`  in  1: logic clock; all state is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_pg_rdy`  in  1: one-cycle pulse; the DPRAM page is full and must be written to DDR3.
- `rd_pg_req`  in  1: one-cycle pulse; the oldest stored page must be read from DDR3 into the DPRAM.
- `flush`  in  1: one-cycle pulse; empties the ring.
- `pg_ack`  in  1: from the transfer block (ui_clk domain); asynchronous here.
- `pg_req`  out  1: page request, registered.
- `pg_optype`  out  1: 1 = DPRAM→DDR3 write, 0 = DDR3→DPRAM read; stable while `pg_req` is high.
- `pg_req_addr`  out  28: `{(17-PG_BITS)'b0, page_idx, 11'b0}`; stable while `pg_req` is high.
- `wr_pg_done`  out  1: one-cycle pulse; the write page has been committed.
- `rd_pg_done`  out  1: one-cycle pulse; the read page is now in the DPRAM.
- `full`  out  1: `count == 2^PG_BITS`.
- `empty`  out  1: `count == 0`.
- `fill_level`  out  PG_BITS+1: `count`.
- `busy`  out  1: state is not IDLE.
- `req_err`  out  1: sticky; a request pulse arrived while the same request type was already pending. Cleared only by reset or `flush`.

## Operation
- `pg_ack` passes through a 2-flop synchronizer to give `ack_s`.
- Pending flags:
  - A `wr_pg_rdy` pulse sets `wr_pend`. A `rd_pg_req` pulse sets `rd_pend`.
  - A pulse arriving while its flag is already set leaves the flag set and sets `req_err`.
  - A flag clears in the cycle its `*_done` pulse is issued.
- States: IDLE, REQ, REL.
- IDLE selection, evaluated every cycle:
  - A write is eligible when `wr_pend && !full`.
  - A read is eligible when `rd_pend && !empty`.
  - Write has priority: the producer's DPRAM page is time-critical.
  - On selection, latch `op` and `page_idx` (`wr_ptr` for a write, `rd_ptr` for a read), then go to REQ.
- REQ: `pg_req` = 1. Go to REL when `ack_s` = 1.
- REL: `pg_req` = 0. When `ack_s` = 0, issue the matching `*_done` pulse and update pointers in the same cycle, then go to IDLE.
  - Write: `wr_ptr` += 1 and `count` += 1.
  - Read: `rd_ptr` += 1 and `count` -= 1.
- Pointers are PG_BITS wide and wrap modulo 2^PG_BITS. `count` is PG_BITS+1 bits and never over- or underflows.
- A write while full, or a read while empty, stays pending with no error and is serviced as soon as it becomes eligible.
- `flush`:
  - In IDLE, it zeroes the pointers, `count`, both pending flags and `req_err` on the next edge.
  - Outside IDLE, it is latched in `flush_pend` and applied in the cycle the state returns to IDLE. The in-flight transfer completes, and its `*_done` and pointer update are discarded by the flush.
  - In IDLE, `flush` outranks selection in the same cycle.
- A request pulse in the same cycle as an applied flush is dropped.
- Reset values: every output is 0 except `empty` = 1. Pointers, `count`, flags and synchronizer are 0; state is IDLE.
- Reset mid-transfer drops `pg_req` immediately. The transfer block must be reset together with this block; no recovery of a half-done page is attempted.

## Timing
- Request pulse at edge n sets the pending flag at n. Selection happens at n+1, so `pg_req` is high from n+2.
- `pg_ack` rising reaches `ack_s` 2–3 cycles later, and `pg_req` falls on the next edge.
- The done pulse occurs one cycle after `ack_s` is seen low.
- With the ack already low at REL entry: minimum 1 cycle in REL.
- Back-to-back transfers have 1 idle cycle between the done pulse and the next `pg_req` rise.
- `full`, `empty` and `fill_level` update on the same edge as the done pulse.

## Structure
- Package `ddr3_pg_pkg` holds the shared definitions:
  - `PG_WORDS` = 256 and `PG_ADDR_SHIFT` = 11.
  - `OP_WR` = 1 and `OP_RD` = 0.
  - The state enum {IDLE, REQ, REL}.
- Sub-module: the existing `sync` synchronizer (ports `clk`, `rst_n`, `a`, `y`) for `pg_ack`.
- The remainder is a single FSM plus pointer and count registers.

## Test plan
- **Single write:** `wr_pg_rdy` pulse, bench acks after 10 cycles.
  - `pg_req` high with `pg_optype` = 1 and `pg_req_addr` = 0x0000000.
  - After release: `wr_pg_done` pulse, `fill_level` = 1, `empty` = 0.
- **Second write then read:**
  - The second write uses addr 0x0000800.
  - A following read uses addr 0x0000000 with `pg_optype` = 0, and `rd_pg_done` leaves `fill_level` = 1.
- **Wrap and full** (`PG_BITS` = 2):
  - 4 writes give `full` = 1. A 5th `wr_pg_rdy` stays pending with no `pg_req`.
  - A read frees a slot, and the 5th write then goes to addr 0x0000000 (wrapped).
- **Simultaneous pending:** both pending with `count` = 1 → write is issued first, then read.
  - Read pending on empty waits with no `pg_req` until a write commits.
- **Errors and flush:**
  - Two `wr_pg_rdy` pulses while pending → `req_err` = 1.
  - `flush` mid-REQ → transfer completes, then `fill_level` = 0, `empty` = 1, `req_err` = 0.
- **Reset during REQ:** `rst_n` low → `pg_req` = 0 asynchronously, all outputs at reset values, `empty` = 1.

Source files
------------

// File: rtl/ddr3_pg_pkg.sv
// ddr3_pg_pkg
// Shared definitions for the DDR3 page ring-buffer manager: page geometry,
// transfer op encoding, FSM state type and the page-to-byte-address helper.
package ddr3_pg_pkg;

    // A page is 256 words of 64 bits, i.e. 2 KiB of DDR3 address space.
    localparam int PG_WORDS      = 256;
    localparam int PG_ADDR_SHIFT = $clog2(PG_WORDS * 8);

    localparam logic OP_WR = 1'b1;  // DPRAM -> DDR3
    localparam logic OP_RD = 1'b0;  // DDR3 -> DPRAM

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } pg_state_e;

    // Byte address of a page; the page index is at most 17 bits wide.
    function automatic logic [27:0] pg_addr(input logic [16:0] page);
        return {page, 11'b0};
    endfunction

endpackage

// File: rtl/sync.sv
// sync
// Two-flop synchronizer for a single-bit level crossing into clk.
// Ports: clk (destination clock), rst_n (async active-low reset),
//        a (asynchronous input), y (synchronized output).
module sync (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= a;
            r_sync <= r_meta;
        end
    end

    assign y = r_sync;

endmodule

// File: rtl/ddr3_pg_ring_mgr.sv
// ddr3_pg_ring_mgr
// Page-level ring-buffer manager for the DDR3 waveform store. Turns page
// "filled"/"wanted" pulses into four-phase page transfer requests, owns the
// write/read pointers and the fill count, and holds requests off at full/empty.
// Ports:
//   clk, rst_n              logic clock, async active-low reset
//   wr_pg_rdy, rd_pg_req    one-cycle page write / page read requests
//   flush                   one-cycle pulse, empties the ring
//   pg_ack                  transfer-block acknowledge (other clock domain)
//   pg_req, pg_optype,      four-phase request, op (1 = write) and byte
//   pg_req_addr             address of the page being moved
//   wr_pg_done, rd_pg_done  one-cycle completion pulses
//   full, empty, fill_level ring occupancy
//   busy                    a transfer is in progress
//   req_err                 sticky: request pulse while already pending
module ddr3_pg_ring_mgr
    import ddr3_pg_pkg::*;
#(
    parameter int PG_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_pg_rdy,
    input  logic               rd_pg_req,
    input  logic               flush,
    input  logic               pg_ack,
    output logic               pg_req,
    output logic               pg_optype,
    output logic [27:0]        pg_req_addr,
    output logic               wr_pg_done,
    output logic               rd_pg_done,
    output logic               full,
    output logic               empty,
    output logic [PG_BITS:0]   fill_level,
    output logic               busy,
    output logic               req_err
);

    localparam logic [PG_BITS:0] FULL_CNT = (PG_BITS + 1)'(1) << PG_BITS;

    pg_state_e            r_state,      w_state_nxt;
    logic [PG_BITS-1:0]   r_wr_ptr,     w_wr_ptr_nxt;
    logic [PG_BITS-1:0]   r_rd_ptr,     w_rd_ptr_nxt;
    logic [PG_BITS:0]     r_count,      w_count_nxt;
    logic                 r_wr_pend,    w_wr_pend_nxt;
    logic                 r_rd_pend,    w_rd_pend_nxt;
    logic                 r_flush_pend, w_flush_pend_nxt;
    logic                 r_req_err,    w_req_err_nxt;
    logic                 r_op,         w_op_nxt;
    logic [PG_BITS-1:0]   r_page,       w_page_nxt;
    logic                 r_pg_req,     w_pg_req_nxt;
    logic                 r_wr_done,    w_wr_done_nxt;
    logic                 r_rd_done,    w_rd_done_nxt;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_busy;

    logic                 w_ack_s;
    logic                 w_flush_any;
    logic                 w_flush_apply;

    sync u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (pg_ack),
        .y     (w_ack_s)
    );

    // Next-state, pointer, flag and output computation for the transfer FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_wr_pend_nxt    = r_wr_pend;
        w_rd_pend_nxt    = r_rd_pend;
        w_flush_pend_nxt = r_flush_pend;
        w_req_err_nxt    = r_req_err;
        w_op_nxt         = r_op;
        w_page_nxt       = r_page;
        w_wr_done_nxt    = 1'b0;
        w_rd_done_nxt    = 1'b0;
        w_flush_apply    = 1'b0;
        w_flush_any      = flush || r_flush_pend;

        case (r_state)
            IDLE: begin
                // Flush (fresh or deferred) outranks starting a transfer.
                if (w_flush_any) begin
                    w_flush_apply = 1'b1;
                end else if (r_wr_pend && !r_full) begin
                    w_op_nxt    = OP_WR;
                    w_page_nxt  = r_wr_ptr;
                    w_state_nxt = REQ;
                end else if (r_rd_pend && !r_empty) begin
                    w_op_nxt    = OP_RD;
                    w_page_nxt  = r_rd_ptr;
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                w_flush_pend_nxt = w_flush_any;
                if (w_ack_s) begin
                    w_state_nxt = REL;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            REL: begin
                w_flush_pend_nxt = w_flush_any;
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    // A pending flush discards the completion of this page.
                    if (!w_flush_any) begin
                        if (r_op == OP_WR) begin
                            w_wr_done_nxt = 1'b1;
                            w_wr_pend_nxt = 1'b0;
                            w_wr_ptr_nxt  = r_wr_ptr + PG_BITS'(1);
                            w_count_nxt   = r_count + (PG_BITS + 1)'(1);
                        end else begin
                            w_rd_done_nxt = 1'b1;
                            w_rd_pend_nxt = 1'b0;
                            w_rd_ptr_nxt  = r_rd_ptr + PG_BITS'(1);
                            w_count_nxt   = r_count - (PG_BITS + 1)'(1);
                        end
                    end else begin
                        w_wr_done_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = REL;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Request pulses coinciding with an applied flush are dropped.
        if (w_flush_apply) begin
            w_wr_ptr_nxt     = '0;
            w_rd_ptr_nxt     = '0;
            w_count_nxt      = '0;
            w_wr_pend_nxt    = 1'b0;
            w_rd_pend_nxt    = 1'b0;
            w_flush_pend_nxt = 1'b0;
            w_req_err_nxt    = 1'b0;
        end else begin
            if (wr_pg_rdy) begin
                if (r_wr_pend) begin
                    w_req_err_nxt = 1'b1;
                end else begin
                    w_req_err_nxt = w_req_err_nxt;
                end
                w_wr_pend_nxt = 1'b1;
            end else begin
                w_wr_pend_nxt = w_wr_pend_nxt;
            end
            if (rd_pg_req) begin
                if (r_rd_pend) begin
                    w_req_err_nxt = 1'b1;
                end else begin
                    w_req_err_nxt = w_req_err_nxt;
                end
                w_rd_pend_nxt = 1'b1;
            end else begin
                w_rd_pend_nxt = w_rd_pend_nxt;
            end
        end

        // pg_req rises one cycle after entering REQ and falls on the edge
        // that leaves REQ, so it is a clean registered level.
        w_pg_req_nxt = (r_state == REQ) && (w_state_nxt == REQ);
    end

    // State, pointer, flag and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_req_err    <= 1'b0;
            r_op         <= 1'b0;
            r_page       <= '0;
            r_pg_req     <= 1'b0;
            r_wr_done    <= 1'b0;
            r_rd_done    <= 1'b0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_wr_pend    <= w_wr_pend_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_req_err    <= w_req_err_nxt;
            r_op         <= w_op_nxt;
            r_page       <= w_page_nxt;
            r_pg_req     <= w_pg_req_nxt;
            r_wr_done    <= w_wr_done_nxt;
            r_rd_done    <= w_rd_done_nxt;
            r_full       <= (w_count_nxt == FULL_CNT);
            r_empty      <= (w_count_nxt == '0);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign pg_req      = r_pg_req;
    assign pg_optype   = r_op;
    assign pg_req_addr = pg_addr(17'(r_page));
    assign wr_pg_done  = r_wr_done;
    assign rd_pg_done  = r_rd_done;
    assign full        = r_full;
    assign empty       = r_empty;
    assign fill_level  = r_count;
    assign busy        = r_busy;
    assign req_err     = r_req_err;

endmodule

// File: tb/tb_ddr3_pg_ring_mgr.sv
// Bench for ddr3_pg_ring_mgr with a 4-page ring. The bench plays the producer,
// the consumer and the transfer block, and predicts every transfer from a
// simple ring model (indices, count, pending flags, sticky error).
module tb_ddr3_pg_ring_mgr;

    localparam int PB   = 2;
    localparam int RING = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_pg_rdy = 1'b0;
    logic          rd_pg_req = 1'b0;
    logic          flush = 1'b0;
    logic          pg_ack = 1'b0;
    logic          pg_req;
    logic          pg_optype;
    logic [27:0]   pg_req_addr;
    logic          wr_pg_done;
    logic          rd_pg_done;
    logic          full;
    logic          empty;
    logic [PB:0]   fill_level;
    logic          busy;
    logic          req_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_wr, m_rd, m_count;
    bit m_wr_pend, m_rd_pend, m_err;
    int ack_dly = 10;

    ddr3_pg_ring_mgr #(.PG_BITS(PB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_pg_rdy   (wr_pg_rdy),
        .rd_pg_req   (rd_pg_req),
        .flush       (flush),
        .pg_ack      (pg_ack),
        .pg_req      (pg_req),
        .pg_optype   (pg_optype),
        .pg_req_addr (pg_req_addr),
        .wr_pg_done  (wr_pg_done),
        .rd_pg_done  (rd_pg_done),
        .full        (full),
        .empty       (empty),
        .fill_level  (fill_level),
        .busy        (busy),
        .req_err     (req_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_wr = 0; m_rd = 0; m_count = 0;
        m_wr_pend = 1'b0; m_rd_pend = 1'b0; m_err = 1'b0;
    endtask

    // One-cycle pulses on the request inputs (DUT idle); model follows.
    task automatic pulse(input bit w, input bit r, input bit f);
        @(negedge clk);
        wr_pg_rdy = w; rd_pg_req = r; flush = f;
        @(negedge clk);
        wr_pg_rdy = 1'b0; rd_pg_req = 1'b0; flush = 1'b0;
        if (f) begin
            model_clear();
        end else begin
            if (w) begin if (m_wr_pend) m_err = 1'b1; m_wr_pend = 1'b1; end
            if (r) begin if (m_rd_pend) m_err = 1'b1; m_rd_pend = 1'b1; end
        end
    endtask

    // Serve the transfer the model says comes next, or confirm none starts.
    task automatic serve_one(input string tag);
        bit          exp_wr;
        logic [27:0] exp_addr;
        int          k;
        bit          seen;
        if (m_wr_pend && m_count < RING) begin
            exp_wr = 1'b1; exp_addr = 28'(m_wr * 2048);
        end else if (m_rd_pend && m_count > 0) begin
            exp_wr = 1'b0; exp_addr = 28'(m_rd * 2048);
        end else begin
            seen = 1'b0;
            repeat (10) begin @(negedge clk); if (pg_req !== 1'b0) seen = 1'b1; end
            n_cmp++;
            if (seen !== 1'b0) begin
                n_fail++; $display("FAIL %s_no_req: pg_req seen=%0b, required 0", tag, seen);
            end
            return;
        end
        k = 0;
        while (pg_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (pg_req !== 1'b1) begin
            n_fail++; $display("FAIL %s_req_timeout: pg_req=%b, required 1", tag, pg_req);
            return;
        end
        n_cmp++;
        if (pg_optype !== exp_wr) begin
            n_fail++; $display("FAIL %s_optype: got %b, required %b", tag, pg_optype, exp_wr);
        end
        n_cmp++;
        if (pg_req_addr !== exp_addr) begin
            n_fail++; $display("FAIL %s_addr: got 0x%07h, required 0x%07h", tag, pg_req_addr, exp_addr);
        end
        repeat (ack_dly) @(negedge clk);
        pg_ack = 1'b1;
        k = 0;
        while (pg_req !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        n_cmp++;
        if (pg_req !== 1'b0) begin
            n_fail++; $display("FAIL %s_req_release: pg_req=%b, required 0", tag, pg_req);
        end
        pg_ack = 1'b0;
        k = 0;
        while (!(wr_pg_done === 1'b1 || rd_pg_done === 1'b1) && k < 10) begin @(negedge clk); k++; end
        if (exp_wr) begin
            m_wr = (m_wr + 1) % RING; m_count++; m_wr_pend = 1'b0;
        end else begin
            m_rd = (m_rd + 1) % RING; m_count--; m_rd_pend = 1'b0;
        end
        n_cmp++;
        if ({wr_pg_done, rd_pg_done} !== (exp_wr ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL %s_done: got wr/rd=%b%b, required %s", tag, wr_pg_done, rd_pg_done, exp_wr ? "10" : "01");
        end
        n_cmp++;
        if ({fill_level, empty, full, busy} !== {(PB + 1)'(m_count), m_count == 0, m_count == RING, 1'b0}) begin
            n_fail++; $display("FAIL %s_occupancy: fill=%0d empty=%b full=%b busy=%b, required fill=%0d empty=%b full=%b busy=0",
                               tag, fill_level, empty, full, busy, m_count, m_count == 0, m_count == RING);
        end
        @(negedge clk);
        n_cmp++;
        if ({wr_pg_done, rd_pg_done} !== 2'b00) begin
            n_fail++; $display("FAIL %s_done_width: got wr/rd=%b%b one cycle later, required 00", tag, wr_pg_done, rd_pg_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pg_req, pg_optype, pg_req_addr, wr_pg_done, rd_pg_done, full, empty, fill_level, busy, req_err}
            !== {1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_values: req=%b op=%b addr=%h done=%b%b full=%b empty=%b fill=%0d busy=%b err=%b, required empty=1 rest 0",
                               pg_req, pg_optype, pg_req_addr, wr_pg_done, rd_pg_done, full, empty, fill_level, busy, req_err);
        end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single_write();
        ack_dly = 10;
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (pg_req !== 1'b0) begin n_fail++; $display("FAIL sw_req_n: pg_req=%b at n, required 0", pg_req); end
        @(negedge clk);
        n_cmp++;
        if ({pg_req, busy} !== 2'b01) begin n_fail++; $display("FAIL sw_req_n1: req/busy=%b%b at n+1, required 01", pg_req, busy); end
        @(negedge clk);
        n_cmp++;
        if (pg_req !== 1'b1) begin n_fail++; $display("FAIL sw_req_n2: pg_req=%b at n+2, required 1", pg_req); end
        serve_one("single_wr");
    endtask

    task automatic test_write_read();
        ack_dly = 3;
        pulse(1'b1, 1'b0, 1'b0);
        serve_one("second_wr");
        pulse(1'b0, 1'b1, 1'b0);
        serve_one("first_rd");
    endtask

    task automatic test_simultaneous();
        ack_dly = 0;
        pulse(1'b1, 1'b1, 1'b0);
        serve_one("sim_wr_first");
        serve_one("sim_rd_second");
        pulse(1'b0, 1'b1, 1'b0);
        serve_one("drain_rd");
        pulse(1'b0, 1'b1, 1'b0);
        serve_one("rd_on_empty");
        pulse(1'b1, 1'b0, 1'b0);
        serve_one("wr_unblocks");
        serve_one("rd_after_wr");
    endtask

    task automatic test_wrap_full();
        ack_dly = 2;
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < RING; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            serve_one("fill_wr");
        end
        n_cmp++;
        if ({full, fill_level} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL full_flag: full=%b fill=%0d, required full=1 fill=4", full, fill_level);
        end
        pulse(1'b1, 1'b0, 1'b0);
        serve_one("wr_on_full");
        pulse(1'b0, 1'b1, 1'b0);
        serve_one("rd_frees");
        serve_one("wrapped_wr");
    endtask

    task automatic test_errors_flush();
        int k;
        bit seen;
        ack_dly = 2;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (req_err !== m_err) begin n_fail++; $display("FAIL req_err_set: got %b, required %b", req_err, m_err); end
        k = 0;
        while (pg_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        pg_ack = 1'b1;
        k = 0;
        while (pg_req !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        pg_ack = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (wr_pg_done === 1'b1 || rd_pg_done === 1'b1) seen = 1'b1; end
        model_clear();
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_discard_done: done seen=%b, required 0", seen); end
        n_cmp++;
        if ({fill_level, empty, req_err, busy} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL flush_state: fill=%0d empty=%b err=%b busy=%b, required 0 1 0 0", fill_level, empty, req_err, busy);
        end
        pulse(1'b1, 1'b0, 1'b1);
        serve_one("req_with_flush_dropped");
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 25; it++) begin
            for (int d = 0; d < 3; d++) begin
                if ((m_wr_pend && m_count < RING) || (m_rd_pend && m_count > 0)) begin
                    ack_dly = $urandom_range(0, 6);
                    serve_one("rnd_drain");
                end
            end
            sel = $urandom_range(0, 3);
            pulse(sel == 0 || sel == 2, sel == 1 || sel == 2, 1'b0);
            ack_dly = $urandom_range(0, 6);
            serve_one("rnd");
            n_cmp++;
            if (req_err !== m_err) begin n_fail++; $display("FAIL rnd_req_err: got %b, required %b (iter %0d)", req_err, m_err, it); end
        end
    endtask

    task automatic test_reset_during_req();
        int k;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        k = 0;
        while (pg_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pg_req, wr_pg_done, rd_pg_done, full, empty, fill_level, busy, req_err}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_req: req=%b done=%b%b full=%b empty=%b fill=%0d busy=%b err=%b, required empty=1 rest 0",
                               pg_req, wr_pg_done, rd_pg_done, full, empty, fill_level, busy, req_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        ack_dly = 1;
        pulse(1'b1, 1'b0, 1'b0);
        serve_one("after_reset_wr");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_read();
        test_simultaneous();
        test_wrap_full();
        test_errors_flush();
        test_random();
        test_reset_during_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
